tl_d_resp_queue: RTL and testbench



---
 rtl/tl_pkg.sv | 23 ++
 rtl/tl_d_resp_queue_if.sv | 56 +++++
 rtl/tl_ring_ptr.sv | 44 ++++
 rtl/tl_d_resp_queue.sv | 119 +++++++++++
 tb/tb_tl_d_resp_queue.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/tl_pkg.sv
// TileLink-UL D-channel shared definitions: opcode constants and the packed
// response record used for queue storage.
package tl_pkg;

  localparam int TL_SOURCE_W = 10;
  localparam int TL_DATA_W   = 32;

  localparam logic [2:0] AccessAck     = 3'd0;
  localparam logic [2:0] AccessAckData = 3'd1;
  localparam logic [2:0] HintAck       = 3'd2;

  typedef struct packed {
    logic [2:0]             opcode;
    logic [1:0]             param;
    logic [1:0]             size;
    logic [TL_SOURCE_W-1:0] source;
    logic                   sink;
    logic                   denied;
    logic                   corrupt;
    logic [TL_DATA_W-1:0]   data;
  } tl_d_t;

endpackage

// File: rtl/tl_d_resp_queue_if.sv
// A-channel observation plus D-channel enqueue/dequeue handshakes of the response queue.
// The slave modport is the queue's view; master is the surrounding fabric's view.
interface tl_d_resp_queue_if #(
  parameter int SOURCE_W = 10,
  parameter int DATA_W   = 32
);

  logic                a_valid;
  logic                a_ready;
  logic                a_allow;

  logic                enq_valid;
  logic                enq_ready;
  logic [2:0]          enq_opcode;
  logic [1:0]          enq_param;
  logic [1:0]          enq_size;
  logic [SOURCE_W-1:0] enq_source;
  logic                enq_sink;
  logic                enq_denied;
  logic                enq_corrupt;
  logic [DATA_W-1:0]   enq_data;

  logic                deq_valid;
  logic                deq_ready;
  logic [2:0]          deq_opcode;
  logic [1:0]          deq_param;
  logic [1:0]          deq_size;
  logic [SOURCE_W-1:0] deq_source;
  logic                deq_sink;
  logic                deq_denied;
  logic                deq_corrupt;
  logic [DATA_W-1:0]   deq_data;

  modport slave (
    input  a_valid, a_ready,
    output a_allow,
    input  enq_valid, enq_opcode, enq_param, enq_size, enq_source,
           enq_sink, enq_denied, enq_corrupt, enq_data,
    output enq_ready,
    input  deq_ready,
    output deq_valid, deq_opcode, deq_param, deq_size, deq_source,
           deq_sink, deq_denied, deq_corrupt, deq_data
  );

  modport master (
    output a_valid, a_ready,
    input  a_allow,
    output enq_valid, enq_opcode, enq_param, enq_size, enq_source,
           enq_sink, enq_denied, enq_corrupt, enq_data,
    input  enq_ready,
    output deq_ready,
    input  deq_valid, deq_opcode, deq_param, deq_size, deq_source,
           deq_sink, deq_denied, deq_corrupt, deq_data
  );

endinterface

// File: rtl/tl_ring_ptr.sv
// Ring-buffer bookkeeping: read/write pointers, the maybe_full disambiguation
// flag, and the derived empty/full/count status.
module tl_ring_ptr #(
  parameter  int DEPTH = 2,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enq_fire,
  input  logic             deq_fire,
  output logic [PTR_W-1:0] wr_ptr,
  output logic [PTR_W-1:0] rd_ptr,
  output logic             empty,
  output logic             full,
  output logic [CNT_W-1:0] count
);

  logic             maybe_full;
  logic             ptr_match;
  logic [PTR_W-1:0] ptr_diff;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      maybe_full <= 1'b0;
    end else begin
      if (enq_fire) wr_ptr <= wr_ptr + PTR_W'(1);
      if (deq_fire) rd_ptr <= rd_ptr + PTR_W'(1);
      // Equal pointers mean empty or full; the last unbalanced operation decides which.
      if (enq_fire != deq_fire) maybe_full <= enq_fire;
    end
  end

  assign ptr_match = (wr_ptr == rd_ptr);
  assign empty     = ptr_match & ~maybe_full;
  assign full      = ptr_match &  maybe_full;
  assign ptr_diff  = wr_ptr - rd_ptr;
  assign count     = full ? CNT_W'(DEPTH) : CNT_W'(ptr_diff);

endmodule

// File: rtl/tl_d_resp_queue.sv
// TileLink-UL D-channel response queue with an outstanding-request tracker
// that throttles the A channel before the response path can overflow.
module tl_d_resp_queue
  import tl_pkg::*;
#(
  parameter  int DEPTH    = 2,
  parameter  int MAX_OUT  = 4,
  parameter  int SOURCE_W = TL_SOURCE_W,
  parameter  int DATA_W   = TL_DATA_W,
  localparam int PTR_W    = $clog2(DEPTH),
  localparam int CNT_W    = $clog2(DEPTH + 1),
  localparam int OUT_W    = $clog2(MAX_OUT + 1)
) (
  input  logic                clock,
  input  logic                reset,
  tl_d_resp_queue_if.slave    bus,
  output logic [CNT_W-1:0]    count,
  output logic [OUT_W-1:0]    outstanding,
  output logic                err_underflow,
  output logic                err_overflow
);

  logic             a_fire;
  logic             enq_fire;
  logic             deq_fire;
  logic             empty;
  logic             full;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  tl_d_t            mem [DEPTH];
  tl_d_t            wr_entry;
  tl_d_t            head;

  logic [OUT_W-1:0] outstanding_next;
  logic             err_underflow_next;
  logic             err_overflow_next;

  assign a_fire        = bus.a_valid & bus.a_ready;
  assign enq_fire      = bus.enq_valid & ~full;
  assign deq_fire      = bus.deq_ready & ~empty;
  assign bus.enq_ready = ~full;
  assign bus.deq_valid = ~empty;

  tl_ring_ptr #(.DEPTH(DEPTH)) u_ring_ptr (
    .clock    (clock),
    .reset    (reset),
    .enq_fire (enq_fire),
    .deq_fire (deq_fire),
    .wr_ptr   (wr_ptr),
    .rd_ptr   (rd_ptr),
    .empty    (empty),
    .full     (full),
    .count    (count)
  );

  assign wr_entry = '{
    opcode:  bus.enq_opcode,
    param:   bus.enq_param,
    size:    bus.enq_size,
    source:  TL_SOURCE_W'(bus.enq_source),
    sink:    bus.enq_sink,
    denied:  bus.enq_denied,
    corrupt: bus.enq_corrupt,
    data:    TL_DATA_W'(bus.enq_data)
  };

  // NOTE: payload storage has no reset; the pointers alone decide which
  // entries are live, so clearing the array would only cost logic.
  always_ff @(posedge clock) begin
    if (enq_fire) mem[wr_ptr] <= wr_entry;
  end

  // No flow-through: the head is always a stored entry.
  assign head            = mem[rd_ptr];
  assign bus.deq_opcode  = head.opcode;
  assign bus.deq_param   = head.param;
  assign bus.deq_size    = head.size;
  assign bus.deq_source  = SOURCE_W'(head.source);
  assign bus.deq_sink    = head.sink;
  assign bus.deq_denied  = head.denied;
  assign bus.deq_corrupt = head.corrupt;
  assign bus.deq_data    = DATA_W'(head.data);

  // NOTE: every output of this always_comb gets a default before the case,
  // so no path leaves a value held and no latch is inferred.
  always_comb begin
    outstanding_next   = outstanding;
    err_underflow_next = err_underflow;
    err_overflow_next  = err_overflow;
    case ({a_fire, deq_fire})
      2'b10: begin
        if (outstanding == OUT_W'(MAX_OUT)) err_overflow_next = 1'b1;
        else                                outstanding_next  = outstanding + OUT_W'(1);
      end
      2'b01: begin
        if (outstanding == '0) err_underflow_next = 1'b1;
        else                   outstanding_next   = outstanding - OUT_W'(1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      outstanding   <= '0;
      err_underflow <= 1'b0;
      err_overflow  <= 1'b0;
    end else begin
      outstanding   <= outstanding_next;
      err_underflow <= err_underflow_next;
      err_overflow  <= err_overflow_next;
    end
  end

  // Registered compare only, so a_allow never loops back through a_valid.
  assign bus.a_allow = (outstanding < OUT_W'(MAX_OUT));

endmodule

// File: tb/tb_tl_d_resp_queue.sv
// Self-checking bench for tl_d_resp_queue: directed scenarios plus random
// traffic, compared every cycle against a queue-based reference model.
module tb_tl_d_resp_queue;
  import tl_pkg::*;

  localparam int DEPTH    = 2;
  localparam int MAX_OUT  = 4;
  localparam int SOURCE_W = 10;
  localparam int DATA_W   = 32;

  logic       clock = 1'b0;
  logic       reset;
  logic [1:0] count;
  logic [2:0] outstanding;
  logic       err_underflow;
  logic       err_overflow;

  tl_d_resp_queue_if #(.SOURCE_W(SOURCE_W), .DATA_W(DATA_W)) bus ();

  tl_d_resp_queue #(
    .DEPTH(DEPTH), .MAX_OUT(MAX_OUT), .SOURCE_W(SOURCE_W), .DATA_W(DATA_W)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .bus           (bus.slave),
    .count         (count),
    .outstanding   (outstanding),
    .err_underflow (err_underflow),
    .err_overflow  (err_overflow)
  );

  always #5 clock = ~clock;

  int    checks = 0;
  int    errors = 0;

  // Reference model: an ordered list of held responses and an in-flight tally.
  tl_d_t q[$];
  int    m_out;
  bit    m_unf;
  bit    m_ovf;
  tl_d_t idle;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic tl_d_t mk(input logic [2:0] op, input logic [9:0] src, input logic [31:0] d);
    tl_d_t e;
    e         = '0;
    e.opcode  = op;
    e.size    = 2'd2;
    e.source  = src;
    e.data    = d;
    return e;
  endfunction

  function automatic tl_d_t rand_entry();
    tl_d_t e;
    e.opcode  = 3'($urandom_range(0, 7));
    e.param   = 2'($urandom_range(0, 3));
    e.size    = 2'($urandom_range(0, 2));
    e.source  = 10'($urandom_range(0, 1023));
    e.sink    = 1'($urandom_range(0, 1));
    e.denied  = 1'($urandom_range(0, 1));
    e.corrupt = 1'($urandom_range(0, 1));
    e.data    = $urandom;
    return e;
  endfunction

  task automatic check_state(input string tag);
    check({tag, ".deq_valid"},   bus.deq_valid,   q.size() != 0);
    check({tag, ".enq_ready"},   bus.enq_ready,   q.size() < DEPTH);
    check({tag, ".count"},       count,           q.size());
    check({tag, ".outstanding"}, outstanding,     m_out);
    check({tag, ".a_allow"},     bus.a_allow,     m_out < MAX_OUT);
    check({tag, ".err_unf"},     err_underflow,   m_unf);
    check({tag, ".err_ovf"},     err_overflow,    m_ovf);
    if (q.size() != 0) begin
      check({tag, ".deq_opcode"},  bus.deq_opcode,  q[0].opcode);
      check({tag, ".deq_param"},   bus.deq_param,   q[0].param);
      check({tag, ".deq_size"},    bus.deq_size,    q[0].size);
      check({tag, ".deq_source"},  bus.deq_source,  q[0].source);
      check({tag, ".deq_sink"},    bus.deq_sink,    q[0].sink);
      check({tag, ".deq_denied"},  bus.deq_denied,  q[0].denied);
      check({tag, ".deq_corrupt"}, bus.deq_corrupt, q[0].corrupt);
      check({tag, ".deq_data"},    bus.deq_data,    q[0].data);
    end
  endtask

  // One clock cycle: drive at the falling edge, compare, then advance the model.
  task automatic step(input string tag, input bit ev, input tl_d_t e, input bit dr,
                      input bit av, input bit ar, input bit rst = 1'b0);
    bit ef, df, af;
    reset           = rst;
    bus.enq_valid   = ev;
    bus.enq_opcode  = e.opcode;
    bus.enq_param   = e.param;
    bus.enq_size    = e.size;
    bus.enq_source  = e.source;
    bus.enq_sink    = e.sink;
    bus.enq_denied  = e.denied;
    bus.enq_corrupt = e.corrupt;
    bus.enq_data    = e.data;
    bus.deq_ready   = dr;
    bus.a_valid     = av;
    bus.a_ready     = ar;
    #1;
    check_state(tag);
    ef = ev && (q.size() < DEPTH);
    df = dr && (q.size() > 0);
    af = av && ar;
    @(posedge clock);
    if (rst) begin
      q.delete();
      m_out = 0;
      m_unf = 1'b0;
      m_ovf = 1'b0;
    end else begin
      if (df) void'(q.pop_front());
      if (ef) q.push_back(e);
      if (af && !df) begin
        if (m_out == MAX_OUT) m_ovf = 1'b1;
        else                  m_out++;
      end else if (df && !af) begin
        if (m_out == 0) m_unf = 1'b1;
        else            m_out--;
      end
    end
    @(negedge clock);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit ev, dr, av, ar;
    idle = '0;

    // Power-up reset: outputs are unknown before the first edge, so no checks yet.
    reset         = 1'b1;
    bus.enq_valid = 1'b0;
    bus.deq_ready = 1'b0;
    bus.a_valid   = 1'b0;
    bus.a_ready   = 1'b0;
    {bus.enq_opcode, bus.enq_param, bus.enq_size, bus.enq_source,
     bus.enq_sink, bus.enq_denied, bus.enq_corrupt, bus.enq_data} = '0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    q.delete();
    m_out = 0;
    m_unf = 1'b0;
    m_ovf = 1'b0;
    check("reset.deq_valid",   bus.deq_valid,  1'b0);
    check("reset.enq_ready",   bus.enq_ready,  1'b1);
    check("reset.count",       count,          2'd0);
    check("reset.outstanding", outstanding,    3'd0);
    check("reset.a_allow",     bus.a_allow,    1'b1);
    check("reset.err_unf",     err_underflow,  1'b0);
    check("reset.err_ovf",     err_overflow,   1'b0);

    // Single pass-through with one matching A request.
    step("pass.enq", 1, mk(AccessAckData, 10'h2A, 32'hDEADBEEF), 1, 1, 1);
    check("pass.deq_valid",  bus.deq_valid,  1'b1);
    check("pass.count1",     count,          2'd1);
    check("pass.deq_opcode", bus.deq_opcode, AccessAckData);
    check("pass.deq_source", bus.deq_source, 10'h2A);
    check("pass.deq_data",   bus.deq_data,   32'hDEADBEEF);
    step("pass.deq", 0, idle, 1, 0, 0);
    check("pass.count0",     count,          2'd0);
    check("pass.deq_valid0", bus.deq_valid,  1'b0);

    // Fill, refuse while full, then wrap.
    step("fill.1", 1, mk(AccessAck, 10'd1, 32'h1111), 0, 1, 1);
    step("fill.2", 1, mk(AccessAck, 10'd2, 32'h2222), 0, 1, 1);
    check("fill.enq_ready", bus.enq_ready,  1'b0);
    check("fill.count",     count,          2'd2);
    check("fill.head1",     bus.deq_source, 10'd1);
    step("fill.refuse", 1, mk(AccessAck, 10'd9, 32'h9999), 1, 1, 1);
    check("fill.after_refuse_count", count,          2'd1);
    check("fill.head2",              bus.deq_source, 10'd2);
    step("wrap.enq3", 1, mk(HintAck, 10'd3, 32'h3333), 0, 0, 0);
    step("wrap.drain2", 0, idle, 1, 0, 0);
    check("wrap.head3", bus.deq_source, 10'd3);
    step("wrap.drain3", 0, idle, 1, 0, 0);
    check("wrap.empty", bus.deq_valid, 1'b0);

    // Simultaneous enqueue and dequeue at count 1.
    step("sim.enq4", 1, mk(AccessAckData, 10'd4, 32'h4444), 0, 1, 1);
    step("sim.both", 1, mk(AccessAckData, 10'd5, 32'h5555), 1, 1, 1);
    check("sim.count",     count,          2'd1);
    check("sim.enq_ready", bus.enq_ready,  1'b1);
    check("sim.head5",     bus.deq_source, 10'd5);
    step("sim.drain", 0, idle, 1, 0, 0);

    // Outstanding saturation and overflow.
    step("out.pre", 1, mk(AccessAck, 10'd6, 32'h6666), 0, 0, 0);
    for (int i = 0; i < 4; i++) step("out.afire", 0, idle, 0, 1, 1);
    check("out.a_allow",     bus.a_allow, 1'b0);
    check("out.outstanding", outstanding, 3'd4);
    step("out.both", 0, idle, 1, 1, 1);
    check("out.both_outstanding", outstanding,  3'd4);
    check("out.both_no_ovf",      err_overflow, 1'b0);
    step("out.ovf", 0, idle, 0, 1, 1);
    check("out.err_ovf",         err_overflow, 1'b1);
    check("out.ovf_outstanding", outstanding,  3'd4);

    // Drain the tracker to zero, then underflow it.
    for (int i = 0; i < 4; i++) step("unf.stream", 1, rand_entry(), 1, 0, 0);
    step("unf.last", 0, idle, 1, 0, 0);
    check("unf.zero",    outstanding,   3'd0);
    check("unf.no_unf",  err_underflow, 1'b0);
    step("unf.enq", 1, rand_entry(), 0, 0, 0);
    step("unf.deq", 0, idle, 1, 0, 0);
    check("unf.err_unf", err_underflow, 1'b1);
    repeat (3) step("unf.idle", 0, idle, 0, 0, 0);
    check("unf.sticky",  err_underflow, 1'b1);

    // Random traffic; mostly well-behaved A-side throttling, sometimes not.
    for (int i = 0; i < 400; i++) begin
      ev = 1'($urandom_range(0, 1));
      dr = ($urandom_range(0, 3) != 0);
      av = 1'($urandom_range(0, 1));
      ar = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) != 0) ar = ar && (m_out < MAX_OUT);
      step("rand", ev, rand_entry(), dr, av, ar, ($urandom_range(0, 99) == 0));
    end

    // Reset mid-stream with both flags set, two entries held, three in flight.
    step("mid.rst", 0, idle, 0, 0, 0, 1'b1);
    step("mid.enq", 1, rand_entry(), 0, 0, 0);
    step("mid.unf", 0, idle, 1, 0, 0);
    step("mid.a1",  1, rand_entry(), 0, 1, 1);
    for (int i = 0; i < 4; i++) step("mid.afire", 0, idle, 0, 1, 1);
    step("mid.swap", 1, rand_entry(), 1, 0, 0);
    step("mid.fill", 1, rand_entry(), 0, 0, 0);
    check("mid.count",       count,         2'd2);
    check("mid.outstanding", outstanding,   3'd3);
    check("mid.err_unf",     err_underflow, 1'b1);
    check("mid.err_ovf",     err_overflow,  1'b1);
    step("mid.pulse", 1, rand_entry(), 1, 1, 1, 1'b1);
    check("mid.deq_valid",   bus.deq_valid, 1'b0);
    check("mid.count0",      count,         2'd0);
    check("mid.out0",        outstanding,   3'd0);
    check("mid.enq_ready",   bus.enq_ready, 1'b1);
    check("mid.unf0",        err_underflow, 1'b0);
    check("mid.ovf0",        err_overflow,  1'b0);
    step("mid.after", 0, idle, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
